// File: rtl/cnn_concat_2in_ctrl.sv
// cnn_concat_2in_ctrl: emit one input-1 frame, then one input-2 frame (input-2 buffered in a FIFO)
// Ports: clk/reset (sync, active-high); valid_in_no1/in_no1, valid_in_no2/in_no2 upstream streams;
// out/valid_out registered concatenated stream; frame_done pulses with the last input-2 word;
// fifo_level occupancy; overflow/protocol_err sticky drop flags; busy while a frame is in progress.
module cnn_concat_2in_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_NO1  = 16,
  parameter int FRAME_NO2  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in_no1,
  input  logic [DATA_WIDTH-1:0] in_no1,
  input  logic                  valid_in_no2,
  input  logic [DATA_WIDTH-1:0] in_no2,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  overflow,
  output logic                  protocol_err,
  output logic                  busy
);
  typedef enum logic {S_NO1, S_NO2} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] cnt1, cnt2;
  logic s2, empty, full, pop, bypass, push, emit, last1, last2;
  logic [DATA_WIDTH-1:0] emit_data;
  always_comb begin
    s2 = state == S_NO2;
    empty = fifo_level == '0;
    full = fifo_level == (ADDR_WIDTH+1)'(FIFO_DEPTH);
    pop = s2 && !empty;
    bypass = s2 && empty && valid_in_no2;
    // a full FIFO still accepts a push when the same cycle pops
    push = valid_in_no2 && !bypass && (!full || pop);
    emit = s2 ? (pop || bypass) : valid_in_no1;
    emit_data = !s2 ? in_no1 : pop ? mem[rd_ptr] : in_no2;
    last1 = !s2 && valid_in_no1 && cnt1 == CNT_WIDTH'(FRAME_NO1 - 1);
    last2 = s2 && emit && cnt2 == CNT_WIDTH'(FRAME_NO2 - 1);
    state_n = last1 ? S_NO2 : last2 ? S_NO1 : state;
  end
  assign busy = s2 || cnt1 != '0 || fifo_level != '0;
  always_ff @(posedge clk)
    if (reset) state <= S_NO1;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_no2;
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      valid_out <= 1'b0;
      frame_done <= 1'b0;
      fifo_level <= '0;
      overflow <= 1'b0;
      protocol_err <= 1'b0;
      cnt1 <= '0;
      cnt2 <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (emit) out <= emit_data;
      valid_out <= emit;
      frame_done <= last2;
      cnt1 <= last1 ? '0 : (!s2 && valid_in_no1) ? cnt1 + CNT_WIDTH'(1) : cnt1;
      cnt2 <= last2 ? '0 : (s2 && emit) ? cnt2 + CNT_WIDTH'(1) : cnt2;
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      fifo_level <= (push && !pop) ? fifo_level + (ADDR_WIDTH+1)'(1) :
                    (pop && !push) ? fifo_level - (ADDR_WIDTH+1)'(1) : fifo_level;
      overflow <= overflow || (valid_in_no2 && !bypass && !push);
      protocol_err <= protocol_err || (s2 && valid_in_no1);
    end
  end
endmodule

// File: tb/tb_cnn_concat_2in_ctrl.sv
// tb_cnn_concat_2in_ctrl: directed and random stimulus against a queue-based reference model
module tb_cnn_concat_2in_ctrl;
  localparam int DW = 32, F1 = 4, F2 = 3, D = 4, AW = 2, CW = 20;
  logic clk = 1'b0, reset = 1'b1;
  logic valid_in_no1 = 1'b0, valid_in_no2 = 1'b0;
  logic [DW-1:0] in_no1 = '0, in_no2 = '0;
  logic [DW-1:0] out;
  logic valid_out, frame_done, overflow, protocol_err, busy;
  logic [AW:0] fifo_level;
  int checks = 0, failures = 0;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_out;
  bit m_valid, m_fd, m_ovf, m_perr, m_in2;
  int m_c1, m_c2, n_valid, n_fd;
  cnn_concat_2in_ctrl #(.DATA_WIDTH(DW), .FRAME_NO1(F1), .FRAME_NO2(F2), .FIFO_DEPTH(D),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .valid_in_no1(valid_in_no1), .in_no1(in_no1),
    .valid_in_no2(valid_in_no2), .in_no2(in_no2), .out(out), .valid_out(valid_out),
    .frame_done(frame_done), .fifo_level(fifo_level), .overflow(overflow),
    .protocol_err(protocol_err), .busy(busy));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input bit r, input bit v1, input logic [DW-1:0] d1, input bit v2, input logic [DW-1:0] d2);
    if (r) begin
      m_q.delete();
      m_out = '0; m_valid = 0; m_fd = 0; m_ovf = 0; m_perr = 0; m_in2 = 0; m_c1 = 0; m_c2 = 0;
      return;
    end
    m_valid = 0;
    m_fd = 0;
    if (!m_in2) begin
      if (v1) begin
        m_out = d1; m_valid = 1; m_c1++;
        if (m_c1 == F1) begin m_c1 = 0; m_in2 = 1; end
      end
      if (v2) begin
        if (m_q.size() < D) m_q.push_back(d2);
        else m_ovf = 1;
      end
    end else begin
      if (v1) m_perr = 1;
      if (m_q.size() > 0) begin
        m_out = m_q.pop_front(); m_valid = 1;
        if (v2) m_q.push_back(d2);
      end else if (v2) begin
        m_out = d2; m_valid = 1;
      end
      if (m_valid) begin
        m_c2++;
        if (m_c2 == F2) begin m_c2 = 0; m_fd = 1; m_in2 = 0; end
      end
    end
  endtask
  task automatic step(input bit r, input bit v1, input logic [DW-1:0] d1, input bit v2, input logic [DW-1:0] d2);
    @(negedge clk);
    reset = r; valid_in_no1 = v1; in_no1 = d1; valid_in_no2 = v2; in_no2 = d2;
    @(posedge clk);
    model(r, v1, d1, v2, d2);
    #1;
    check("out", out, m_out);
    check("valid_out", DW'(valid_out), DW'(m_valid));
    check("frame_done", DW'(frame_done), DW'(m_fd));
    check("fifo_level", DW'(fifo_level), DW'(m_q.size()));
    check("overflow", DW'(overflow), DW'(m_ovf));
    check("protocol_err", DW'(protocol_err), DW'(m_perr));
    check("busy", DW'(busy), DW'(m_in2 || m_c1 != 0 || m_q.size() != 0));
    if (valid_out) n_valid++;
    if (frame_done) n_fd++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
  endtask
  initial begin
    step(1, 0, '0, 0, '0);
    step(1, 0, '0, 0, '0);
    // sequential frame, bypass path
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(i), 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, DW'(32'hA0 + i));
    idle(2);
    // interleaved: input-2 buffered while input-1 forwarded
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(16 + i), i <= 3, DW'(32'hB0 + i));
    idle(4);
    check("level_drained", DW'(fifo_level), '0);
    // overflow: five input-2 words during S_NO1
    step(0, 0, '0, 1, 32'hE0);
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(32 + i), 1, DW'(32'hE0 + i));
    check("overflow_set", DW'(overflow), 1);
    idle(4);
    check("carry_level", DW'(fifo_level), 1);
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(48 + i), 0, '0);
    idle(4);
    check("overflow_sticky", DW'(overflow), 1);
    // push/pop collision at full-speed S_NO2 entry, plus protocol error
    step(1, 0, '0, 0, '0);
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(64 + i), i <= 2, DW'(32'hC0 + i));
    step(0, 1, 32'h55, 1, 32'hC3);
    idle(3);
    check("perr_set", DW'(protocol_err), 1);
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(80 + i), 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, DW'(32'hD0 + i));
    // reset mid-frame, then count a clean frame
    step(0, 1, 32'h91, 1, 32'hF1);
    step(0, 1, 32'h92, 0, '0);
    step(1, 0, '0, 0, '0);
    check("rst_busy", DW'(busy), 0);
    n_valid = 0; n_fd = 0;
    for (int i = 1; i <= 4; i++) step(0, 1, DW'(96 + i), 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, DW'(32'hF8 + i));
    idle(3);
    check("frame_outputs", DW'(n_valid), 7);
    check("frame_dones", DW'(n_fd), 1);
    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 249) == 0, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 4) < 2, $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
